// File: rtl/turf_udp_tx_arbiter_pkg.sv
// rtl/turf_udp_tx_arbiter_pkg.sv - shared constants and state type for the UDP TX arbiter
// Contents: UDP header field offsets, stream widths, FSM state encoding.
package turf_udp_tx_arbiter_pkg;

    localparam int UDP_HDR_IP_LSB   = 32;
    localparam int UDP_HDR_PORT_LSB = 16;
    localparam int UDP_HDR_LEN_LSB  = 0;

    localparam int HDR_W  = 64;
    localparam int USER_W = 16;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HDR  = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/turf_udp_tx_arbiter_if.sv
// rtl/turf_udp_tx_arbiter_if.sv - N-lane UDP header + payload stream bundle
// Signals (per lane): udphdr_tdata/tuser/tvalid/tready, udpdata_tdata/tkeep/tlast/tvalid/tready.
// Modports: master drives data/valid and receives ready; slave is the reverse.
interface turf_udp_tx_arbiter_if #(
    parameter int N = 1
);
    import turf_udp_tx_arbiter_pkg::*;

    logic [N*HDR_W-1:0]  udphdr_tdata;
    logic [N*USER_W-1:0] udphdr_tuser;
    logic [N-1:0]        udphdr_tvalid;
    logic [N-1:0]        udphdr_tready;
    logic [N*DATA_W-1:0] udpdata_tdata;
    logic [N*KEEP_W-1:0] udpdata_tkeep;
    logic [N-1:0]        udpdata_tlast;
    logic [N-1:0]        udpdata_tvalid;
    logic [N-1:0]        udpdata_tready;

    modport master (
        output udphdr_tdata, udphdr_tuser, udphdr_tvalid,
        input  udphdr_tready,
        output udpdata_tdata, udpdata_tkeep, udpdata_tlast, udpdata_tvalid,
        input  udpdata_tready
    );

    modport slave (
        input  udphdr_tdata, udphdr_tuser, udphdr_tvalid,
        output udphdr_tready,
        input  udpdata_tdata, udpdata_tkeep, udpdata_tlast, udpdata_tvalid,
        output udpdata_tready
    );

endinterface

// File: rtl/turf_udp_tx_arbiter_rr_pick.sv
// rtl/turf_udp_tx_arbiter_rr_pick.sv - combinational round-robin pick (module turf_rr_pick)
// Ports: i_req (request vector), i_last (previous winner), o_found, o_idx (next winner).
// The winner is the first set request scanning upward from i_last+1, wrapping modulo N.
module turf_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    int w_dist;
    int w_best;

    // Each candidate's distance past i_last; the smallest requesting distance wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_dist  = 0;
        w_best  = N;
        for (int c = 0; c < N; c++) begin
            w_dist = (c - int'(i_last) - 1 + 2 * N) % N;
            if (i_req[c] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_found = 1'b1;
                o_idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/turf_udp_tx_arbiter.sv
// rtl/turf_udp_tx_arbiter.sv - packet-granular round-robin arbiter for the shared UDP TX path
// Ports: clk, rst_n (async active-low); s_udp (NUM_REQ requester lanes, slave side);
//        m_udp (single lane into the UDP core, master side); grant_idx; busy;
//        pkt_count (NUM_REQ x 32, only with TURF_UDP_ARB_STATS_EN defined).
module turf_udp_tx_arbiter
    import turf_udp_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    turf_udp_tx_arbiter_if.slave  s_udp,
    turf_udp_tx_arbiter_if.master m_udp,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
`ifdef TURF_UDP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0] pkt_count
`endif
);

    arb_state_t          r_state,  w_state_nxt;
    logic [IDX_W-1:0]    r_grant_idx, w_grant_nxt;
    logic [IDX_W-1:0]    r_last_grant, w_last_nxt;
    logic                w_pick_found;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [NUM_REQ-1:0]  w_grant_oh;

    logic [HDR_W-1:0]    w_hdr_tdata;
    logic [USER_W-1:0]   w_hdr_tuser;
    logic                w_hdr_tvalid;
    logic [DATA_W-1:0]   w_dat_tdata;
    logic [KEEP_W-1:0]   w_dat_tkeep;
    logic                w_dat_tlast;
    logic                w_dat_tvalid;
    logic                w_last_beat;

    turf_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (s_udp.udphdr_tvalid),
        .i_last  (r_last_grant),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_idx;

    // Select the granted lane; outputs below decide whether it is exposed.
    always_comb begin
        w_hdr_tdata  = '0;
        w_hdr_tuser  = '0;
        w_hdr_tvalid = 1'b0;
        w_dat_tdata  = '0;
        w_dat_tkeep  = '0;
        w_dat_tlast  = 1'b0;
        w_dat_tvalid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_idx == IDX_W'(i)) begin
                w_hdr_tdata  = s_udp.udphdr_tdata[i*HDR_W +: HDR_W];
                w_hdr_tuser  = s_udp.udphdr_tuser[i*USER_W +: USER_W];
                w_hdr_tvalid = s_udp.udphdr_tvalid[i];
                w_dat_tdata  = s_udp.udpdata_tdata[i*DATA_W +: DATA_W];
                w_dat_tkeep  = s_udp.udpdata_tkeep[i*KEEP_W +: KEEP_W];
                w_dat_tlast  = s_udp.udpdata_tlast[i];
                w_dat_tvalid = s_udp.udpdata_tvalid[i];
            end
        end
    end

    assign w_last_beat = (r_state == ARB_DATA) && w_dat_tvalid && m_udp.udpdata_tready && w_dat_tlast;

    always_comb begin
        w_state_nxt          = r_state;
        w_grant_nxt          = r_grant_idx;
        w_last_nxt           = r_last_grant;
        m_udp.udphdr_tdata   = '0;
        m_udp.udphdr_tuser   = '0;
        m_udp.udphdr_tvalid  = 1'b0;
        m_udp.udpdata_tdata  = '0;
        m_udp.udpdata_tkeep  = '0;
        m_udp.udpdata_tlast  = 1'b0;
        m_udp.udpdata_tvalid = 1'b0;
        s_udp.udphdr_tready  = '0;
        s_udp.udpdata_tready = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ARB_HDR;
                end
            end
            ARB_HDR: begin
                m_udp.udphdr_tdata  = w_hdr_tdata;
                m_udp.udphdr_tuser  = w_hdr_tuser;
                m_udp.udphdr_tvalid = w_hdr_tvalid;
                s_udp.udphdr_tready = m_udp.udphdr_tready[0] ? w_grant_oh : '0;
                if (w_hdr_tvalid && m_udp.udphdr_tready[0]) begin
                    w_state_nxt = ARB_DATA;
                end
            end
            ARB_DATA: begin
                m_udp.udpdata_tdata  = w_dat_tdata;
                m_udp.udpdata_tkeep  = w_dat_tkeep;
                m_udp.udpdata_tlast  = w_dat_tlast;
                m_udp.udpdata_tvalid = w_dat_tvalid;
                s_udp.udpdata_tready = m_udp.udpdata_tready[0] ? w_grant_oh : '0;
                if (w_last_beat) begin
                    w_last_nxt  = r_grant_idx;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Reset leaves requester 0 with top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant_idx  <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    assign grant_idx = r_grant_idx;
    assign busy      = (r_state != ARB_IDLE);

`ifdef TURF_UDP_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] r_pkt_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_last_beat && (r_grant_idx == IDX_W'(i))) begin
                    r_pkt_count[i*32 +: 32] <= r_pkt_count[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_turf_udp_tx_arbiter.sv
// tb/tb_turf_udp_tx_arbiter.sv - directed self-checking bench for turf_udp_tx_arbiter
module tb_turf_udp_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    turf_udp_tx_arbiter_if #(.N(4)) s_if ();
    turf_udp_tx_arbiter_if #(.N(1)) m_if ();

    logic [1:0] grant_idx;
    logic       busy;
`ifdef TURF_UDP_ARB_STATS_EN
    logic [127:0] pkt_count;
`endif

    turf_udp_tx_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_udp     (s_if),
        .m_udp     (m_if),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef TURF_UDP_ARB_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    logic [63:0] hd [4];
    logic [15:0] hu [4];
    logic        hv [4];
    logic [63:0] dd [4];
    logic [7:0]  dk [4];
    logic        dl [4];
    logic        dv [4];
    logic        m_hdr_rdy = 1'b1;
    logic        m_dat_rdy;
    int          rdy_mode = 0;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign s_if.udphdr_tdata[g*64 +: 64] = hd[g];
        assign s_if.udphdr_tuser[g*16 +: 16] = hu[g];
        assign s_if.udphdr_tvalid[g]         = hv[g];
        assign s_if.udpdata_tdata[g*64 +: 64] = dd[g];
        assign s_if.udpdata_tkeep[g*8 +: 8]   = dk[g];
        assign s_if.udpdata_tlast[g]          = dl[g];
        assign s_if.udpdata_tvalid[g]         = dv[g];
    end
    assign m_if.udphdr_tready[0]  = m_hdr_rdy;
    assign m_if.udpdata_tready[0] = m_dat_rdy;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = held high, 1 = toggling, otherwise held low.
    initial begin
        m_dat_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_dat_rdy = 1'b1;
                1:       m_dat_rdy = ~m_dat_rdy;
                default: m_dat_rdy = 1'b0;
            endcase
        end
    end

    // Output monitor and protocol-rule observer.
    logic [63:0] hdr_log [$];
    logic [15:0] usr_log [$];
    logic [1:0]  gid_log [$];
    logic [63:0] dat_log [$];
    logic [7:0]  kep_log [$];
    logic        lst_log [$];
    int          viol = 0;
    bit          in_pkt = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    if ((s_if.udphdr_tready[i] || s_if.udpdata_tready[i]) && (i != int'(grant_idx))) viol++;
                end
                if (|s_if.udphdr_tready && |s_if.udpdata_tready) viol++;
                if (m_if.udphdr_tvalid[0] && m_hdr_rdy) begin
                    if (in_pkt) viol++;
                    in_pkt = 1'b1;
                    hdr_log.push_back(m_if.udphdr_tdata);
                    usr_log.push_back(m_if.udphdr_tuser);
                    gid_log.push_back(grant_idx);
                end
                if (m_if.udpdata_tvalid[0] && m_dat_rdy) begin
                    if (!in_pkt) viol++;
                    dat_log.push_back(m_if.udpdata_tdata);
                    kep_log.push_back(m_if.udpdata_tkeep);
                    lst_log.push_back(m_if.udpdata_tlast[0]);
                    if (m_if.udpdata_tlast[0]) in_pkt = 1'b0;
                end
            end
        end
    end

    task automatic wait_rdy(input bit is_data, input int l);
        int n = 0;
        forever begin
            @(negedge clk);
            if (is_data ? s_if.udpdata_tready[l] : s_if.udphdr_tready[l]) begin
                @(posedge clk);
                #1;
                return;
            end
            n++;
            if (n > 300) begin
                check($sformatf("hs_timeout_lane%0d", l), 64'(n), 64'd0);
                return;
            end
        end
    endtask

    // Header and first payload beat are presented together on purpose.
    task automatic send(input int l, input logic [63:0] h, input logic [15:0] u, input int nb,
                        input logic [7:0] lk, input logic [63:0] base, input int stall_at);
        fork
            begin
                hd[l] = h; hu[l] = u; hv[l] = 1'b1;
                wait_rdy(1'b0, l);
                hv[l] = 1'b0;
            end
            begin
                for (int b = 0; b < nb; b++) begin
                    dd[l] = base + 64'(b);
                    dk[l] = (b == nb - 1) ? lk : 8'hFF;
                    dl[l] = (b == nb - 1);
                    dv[l] = 1'b1;
                    wait_rdy(1'b1, l);
                    dv[l] = 1'b0;
                    if (b == stall_at) begin
                        repeat (10) @(posedge clk);
                        #1;
                    end
                end
            end
        join
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            hd[i] = '0; hu[i] = '0; hv[i] = 1'b0;
            dd[i] = '0; dk[i] = '0; dl[i] = 1'b0; dv[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        hdr_log.delete(); usr_log.delete(); gid_log.delete();
        dat_log.delete(); kep_log.delete(); lst_log.delete();
        viol = 0;
        in_pkt = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [63:0] exp_d [5] = '{64'h000, 64'h100, 64'h200, 64'h300, 64'h001};
    logic [63:0] exp_s [4] = '{64'h0A00, 64'h0A01, 64'h0A02, 64'h3300};

    initial begin
        // Reset state
        reset_dut();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_m_hvalid", 64'(m_if.udphdr_tvalid), 64'd0);
        check("rst_m_dvalid", 64'(m_if.udpdata_tvalid), 64'd0);
        check("rst_s_ready", 64'({s_if.udphdr_tready, s_if.udpdata_tready}), 64'd0);

        // Single requester 1, 2-beat payload
        send(1, 64'hC0A8_0101_1F40_0010, 16'h1234, 2, 8'hFF, 64'h1000, -1);
        check("t2_nhdr", 64'(hdr_log.size()), 64'd1);
        check("t2_hdr", hdr_log[0], 64'hC0A8_0101_1F40_0010);
        check("t2_user", 64'(usr_log[0]), 64'h1234);
        check("t2_gid", 64'(gid_log[0]), 64'd1);
        check("t2_ndat", 64'(dat_log.size()), 64'd2);
        check("t2_d0", dat_log[0], 64'h1000);
        check("t2_d1", dat_log[1], 64'h1001);
        check("t2_last", 64'({lst_log[0], lst_log[1]}), 64'b01);
        check("t2_viol", 64'(viol), 64'd0);
        check("t2_grant_out", 64'(grant_idx), 64'd1);
        check("t2_busy_after", 64'(busy), 64'd0);

        // All four requesting, 1-beat packets, requester 0 sends twice
        reset_dut();
        fork
            begin
                send(0, 64'hA0, 16'h0, 1, 8'hFF, 64'h000, -1);
                send(0, 64'hA1, 16'h0, 1, 8'hFF, 64'h001, -1);
            end
            send(1, 64'hB0, 16'h1, 1, 8'hFF, 64'h100, -1);
            send(2, 64'hC0, 16'h2, 1, 8'hFF, 64'h200, -1);
            send(3, 64'hD0, 16'h3, 1, 8'hFF, 64'h300, -1);
        join
        check("t3_nhdr", 64'(gid_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_gid%0d", i), 64'(gid_log[i]), 64'(exp_g[i]));
            check($sformatf("t3_dat%0d", i), dat_log[i], exp_d[i]);
        end
        check("t3_viol", 64'(viol), 64'd0);

        // Requester 2, 5 beats, downstream ready toggling
        reset_dut();
        rdy_mode = 1;
        send(2, 64'h0A00_0002_0050_0028, 16'h5555, 5, 8'h0F, 64'h2000, -1);
        rdy_mode = 0;
        check("t4_ndat", 64'(dat_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_dat%0d", i), dat_log[i], 64'h2000 + 64'(i));
            check($sformatf("t4_keep%0d", i), 64'(kep_log[i]), (i == 4) ? 64'h0F : 64'hFF);
        end
        check("t4_last", 64'(lst_log[4]), 64'd1);
        check("t4_viol", 64'(viol), 64'd0);

        // Requester 0 stalls mid-packet while requester 3 waits
        reset_dut();
        fork
            send(0, 64'hE0, 16'h0, 3, 8'hFF, 64'h0A00, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(3, 64'hF3, 16'h3, 1, 8'hFF, 64'h3300, -1);
            end
            begin
                repeat (6) @(negedge clk);
                check("t5_stall_grant", 64'(grant_idx), 64'd0);
                check("t5_stall_dvalid", 64'(m_if.udpdata_tvalid), 64'd0);
                check("t5_stall_hvalid", 64'(m_if.udphdr_tvalid), 64'd0);
            end
        join
        check("t5_gid0", 64'(gid_log[0]), 64'd0);
        check("t5_gid1", 64'(gid_log[1]), 64'd3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_dat%0d", i), dat_log[i], exp_s[i]);
        end
        check("t5_viol", 64'(viol), 64'd0);

        // Reset asserted while requester 1 is in DATA
        reset_dut();
        rdy_mode = 2;
        hd[1] = 64'h1111; hu[1] = 16'h1; hv[1] = 1'b1;
        dd[1] = 64'h5151; dk[1] = 8'hFF; dl[1] = 1'b0; dv[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_pre_grant", 64'(grant_idx), 64'd1);
        check("t6_pre_dvalid", 64'(m_if.udpdata_tvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_grant", 64'(grant_idx), 64'd0);
        check("t6_rst_mvalid", 64'({m_if.udphdr_tvalid, m_if.udpdata_tvalid}), 64'd0);
        check("t6_rst_sready", 64'({s_if.udphdr_tready, s_if.udpdata_tready}), 64'd0);
        hd[0] = 64'h0F0F; hv[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_post_grant", 64'(grant_idx), 64'd0);
        check("t6_post_hdr", m_if.udphdr_tdata, 64'h0F0F);

`ifdef TURF_UDP_ARB_STATS_EN
        reset_dut();
        for (int i = 0; i < 3; i++) send(2, 64'h22, 16'h2, 2, 8'hFF, 64'h2200, -1);
        send(0, 64'h00, 16'h0, 1, 8'hFF, 64'h0100, -1);
        check("t7_cnt0", 64'(pkt_count[0 +: 32]), 64'd1);
        check("t7_cnt1", 64'(pkt_count[32 +: 32]), 64'd0);
        check("t7_cnt2", 64'(pkt_count[64 +: 32]), 64'd3);
        check("t7_cnt3", 64'(pkt_count[96 +: 32]), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/turf_udp_tx_arbiter.md
Name: turf_udp_tx_arbiter

Overview:
- Shares the single UDP transmit path (header stream + payload stream into the UDP/MAC core) between NUM_REQ independent requesters (control, event readout, housekeeping, ...).
- Round-robin, packet-granular arbitration: a grant covers one header beat plus the complete payload up to and including tlast.
- Sits directly in front of the UDP core's s_udphdr_/s_udpdata_ inputs, in the core logic clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, grant index width, $clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  core logic clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_udphdr_tdata  in  NUM_REQ*64  per-requester header: [32+:32] dst ip, [16+:16] dst port, [0+:16] length.
- s_udphdr_tuser  in  NUM_REQ*16  per-requester source port.
- s_udphdr_tvalid  in  NUM_REQ  header valid.
- s_udphdr_tready  out  NUM_REQ  header ready.
- s_udpdata_tdata  in  NUM_REQ*64  payload data.
- s_udpdata_tkeep  in  NUM_REQ*8  payload byte enables.
- s_udpdata_tlast  in  NUM_REQ  payload end.
- s_udpdata_tvalid  in  NUM_REQ  payload valid.
- s_udpdata_tready  out  NUM_REQ  payload ready.
- m_udphdr_tdata  out  64  header to UDP core, same field layout.
- m_udphdr_tuser  out  16  source port to UDP core.
- m_udphdr_tvalid  out  1.
- m_udphdr_tready  in  1.
- m_udpdata_tdata  out  64;  m_udpdata_tkeep  out  8;  m_udpdata_tlast  out  1;  m_udpdata_tvalid  out  1;  m_udpdata_tready  in  1.
- grant_idx  out  IDX_W  index of the current or last owner.
- busy  out  1  high in HDR or DATA.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, grant_idx=0, last_grant=NUM_REQ-1 (requester 0 wins first), busy=0. All tvalid/tready outputs are 0.
- FSM IDLE:
  - If any s_udphdr_tvalid is set, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the choice into grant_idx and go to HDR.
  - Grant takes 1 cycle; no tready is asserted in IDLE.
- FSM HDR:
  - m_udphdr_* is a combinational mux of the granted requester.
  - s_udphdr_tready[grant_idx] = m_udphdr_tready; all other readies are 0.
  - On the header handshake go to DATA.
- FSM DATA:
  - m_udpdata_* is muxed from grant_idx; s_udpdata_tready[grant_idx] = m_udpdata_tready; others are 0.
  - m_udphdr_tvalid = 0.
  - On a handshake with tlast=1: last_grant <= grant_idx, go to IDLE.
- Throughput: at least 1 idle cycle between packets. Minimum packet cost is 3 cycles for a 1-beat payload with ready held high.
- Valid is never gated by ready, and the block never drops or duplicates a beat.
- A requester deasserting tvalid mid-packet stalls the output; the grant is not revoked. There is no timeout.
- Payload beats presented before the requester holds the grant are not consumed.
- Simultaneous requests: strict round-robin. A requester that just finished has lowest priority on the next IDLE.
- A single requester may send back-to-back packets when it is the only one requesting.
- The length field passes through unmodified; the arbiter does not check it against the beat count.
- rst_n asserted mid-packet: immediate return to IDLE with all outputs 0. The downstream partial frame is the UDP core's responsibility.

Optional Feature:
- Macro: TURF_UDP_ARB_STATS_EN.
- When defined:
  - Output pkt_count, NUM_REQ*32 bits, one counter per requester.
  - A counter increments on its requester's tlast handshake and wraps at 2^32-1 → 0.
  - Counters reset to 0.
- When undefined: the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared include turf_udp_defs.vh holds:
  - header field offsets: UDP_HDR_IP_LSB=32, UDP_HDR_PORT_LSB=16, UDP_HDR_LEN_LSB=0;
  - state encodings ARB_IDLE=0, ARB_HDR=1, ARB_DATA=2.
- One sub-module, turf_rr_pick: combinational round-robin pick taking request vector and last index, returning a found flag and the next index. It is reusable by the RX-side demux.

Test Plan:
- Only req 1 valid: header 0xC0A8_0101_1F40_0010, tuser 0x1234, 2 payload beats → one header with identical tdata and tuser out, 2 data beats, grant_idx=1, s_*_tready[0,2,3] never high.
- All 4 requests held continuously, 1-beat packets → grant order 0,1,2,3,0; no interleaving of beats across packets.
- m_udpdata_tready toggling 1/0 while req 2 sends 5 beats → all 5 beats delivered in order with unchanged tkeep; last beat tkeep=0x0F.
- Req 0 drops payload tvalid for 10 cycles mid-packet while req 3 is waiting → output stalls and req 3 is granted only after req 0's tlast.
- rst_n pulsed low during DATA on req 1 → all valids/readies 0 in the same cycle. After release, req 0 (if requesting) wins first.
- With TURF_UDP_ARB_STATS_EN: 3 packets from req 2 and 1 from req 0 → pkt_count[2]=3, pkt_count[0]=1, others 0.
